// File: rtl/inst_fetch_unit.sv
// RV32I instruction-fetch unit: owns the PC, reads the ROM combinationally and buffers
// {PC, instruction} pairs for decode. Optional counters enabled by FETCH_PERF_CNT_EN.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        iClk,
   input  logic        iRst_n,
   output logic [31:0] oRdAddr,
   input  logic [31:0] iRdData,
   input  logic        iRedirect,
   input  logic [31:0] iRedirectPc,
   output logic        oInstValid,
   output logic [31:0] oInst,
   output logic [31:0] oInstPc,
   input  logic        iInstReady
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] oFetchCnt,
   output logic [31:0] oStallCnt
`endif
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
   localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end

   logic [31:0]     pc_q, pc_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [31:0]     buf_pc_q   [FIFO_DEPTH];
   logic [31:0]     buf_inst_q [FIFO_DEPTH];

   logic pop;
   logic push;
   logic full;
   logic unused_redirect_lsb;

   // Redirect targets are word aligned; the low bits are dropped on purpose.
   assign unused_redirect_lsb = ^iRedirectPc[1:0];

   assign full       = (count_q == DepthCnt);
   assign pop        = (count_q != '0) & iInstReady;
   assign push       = ~iRedirect & (~full | pop);

   assign oRdAddr    = pc_q;
   assign oInstValid = (count_q != '0);
   assign oInst      = buf_inst_q[rd_ptr_q];
   assign oInstPc    = buf_pc_q[rd_ptr_q];

   always_comb begin
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (iRedirect) begin
         // Flush: a same-cycle pop has already been seen by decode, the rest is dropped.
         pc_d     = {iRedirectPc[31:2], 2'b00};
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_d     = pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         pc_q     <= ResetPcAligned;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            buf_pc_q[i]   <= '0;
            buf_inst_q[i] <= '0;
         end
      end else if (push) begin
         buf_pc_q[wr_ptr_q]   <= pc_q;
         buf_inst_q[wr_ptr_q] <= iRdData;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (push) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (full && !pop && !iRedirect) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign oFetchCnt = fetch_cnt_q;
   assign oStallCnt = stall_cnt_q;
`endif

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch initiator for the RV32I core: owns the PC, drives word addresses into the instruction ROM's combinational read port, and captures the returned instruction in the same cycle.
- Buffers fetched {PC, instruction} pairs in a small FIFO.
- Presents them to decode over a valid/ready handshake.
- Supports a single-cycle redirect from branch/jump resolution, which flushes everything in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, entries in the fetch buffer; power of two, minimum 2.

Ports:
- iClk  input  1  system clock; all state updates on the rising edge.
- iRst_n  input  1  synchronous, active-low reset.
- oRdAddr  output  32  byte address to the instruction ROM; always the current PC; bits [1:0] always 0.
- iRdData  input  32  ROM read data, combinational from oRdAddr in the same cycle.
- iRedirect  input  1  redirect request from execute.
- iRedirectPc  input  32  redirect target; bits [1:0] are ignored and forced to 0.
- oInstValid  output  1  buffer head holds a valid instruction.
- oInst  output  32  instruction at the buffer head.
- oInstPc  output  32  PC of oInst.
- iInstReady  input  1  decode accepts the head this cycle.

Behaviour:
Clock and reset:
- One clock. Reset is synchronous and active-low, through iRst_n sampled on the rising edge of iClk.
- Reset values: PC = RESET_PC, FIFO count = 0, read/write pointers = 0, oInstValid = 0, oInst = 0, oInstPc = 0.

Pop and push conditions:
- pop = oInstValid & iInstReady.
- push = ~iRedirect & (count < FIFO_DEPTH | pop). In words, a slot is free now or is being freed by a pop this cycle.

On push:
- Write {PC, iRdData} at the write pointer.
- PC <= PC + 4, modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.

When the buffer is full and nothing pops:
- PC holds.
- ROM read is repeated, with no side effects.

On iRedirect = 1:
- PC <= {iRedirectPc[31:2], 2'b00}.
- FIFO flushes: count = 0, pointers = 0.
- No push this cycle.
- A simultaneous pop still counts as a completed handshake for decode. The remaining entries are discarded.
- oInstValid = 0 in the next cycle.

Latency:
- Reset released or redirect, then the first instruction is valid one cycle later: the fetch happens in the cycle after the redirect/reset edge and is registered at the following edge.
- Steady state with iInstReady held high: one instruction per cycle, in PC order, with no bubbles.

Outputs:
- oInst/oInstPc are the registered head entry, stable while oInstValid = 1 and iInstReady = 0.
- oInstValid = (count != 0).

Count update:
- count +1 on push-only, -1 on pop-only, unchanged on push & pop.

Reset mid-operation:
- Overrides redirect and handshake.
- Any buffered instructions are lost.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output oFetchCnt [31:0], which increments on every push.
  - Adds output oStallCnt [31:0], which increments on every cycle with count == FIFO_DEPTH & ~pop & ~iRedirect.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined:
  - Neither port nor counter exists.
  - All other behaviour is identical.

Test Plan:
1. Reset, then release with ROM word 0 = 32'h001102B3 and iInstReady = 1 → first cycle after release: oRdAddr = 0. Next cycle: oInstValid = 1, oInst = 32'h001102B3, oInstPc = 0. Then PCs 4, 8, 12 on consecutive cycles.
2. iInstReady = 0 from reset with FIFO_DEPTH = 2 → buffer fills to 2 entries (PCs 0, 4). oRdAddr then holds at 8. oInst/oInstPc stay at PC 0. Raising iInstReady then drains 0, 4, 8 with no gap or duplicate.
3. Buffer full, then iRedirect = 1 with iRedirectPc = 32'h0000_0023 → next cycle: oInstValid = 0, oRdAddr = 32'h0000_0020. One cycle later: oInstPc = 32'h20.
4. iRedirect and a pop in the same cycle (head PC 4) → PC 4 is consumed, PC 8 is discarded. The next valid instruction is at the redirect target.
5. Redirect to 32'hFFFF_FFFC, iInstReady = 1 → oInstPc sequence FFFF_FFFC, 0000_0000, 0000_0004.
6. iRst_n = 0 asserted while 2 entries are buffered → after the next edge, oInstValid = 0 and oRdAddr = RESET_PC. With FETCH_PERF_CNT_EN defined, oFetchCnt = 0 and oStallCnt = 0. In scenario 2, oStallCnt increments once per full-and-stalled cycle.
